// File: rtl/uart_program_loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
package uart_program_loader_pkg;

  localparam logic [7:0] SyncByte = 8'hA5;

  typedef enum logic [1:0] {StIdle, StLen, StData, StChk} loader_state_e;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchroniser, mid-bit sampling, stop-bit framing check.
module uart_rx_byte
  import uart_program_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfBit = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullBit = CntW'(CLKS_PER_BIT - 1);

  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RxIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        if (cnt_q == HalfBit) begin
          // A start bit that is high again at mid-bit was only a glitch.
          state_d = rx_sync_q ? RxIdle : RxData;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (cnt_q == FullBit) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RxStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (cnt_q == FullBit) begin
          state_d = RxIdle;
          valid_d = rx_sync_q;
          ferr_d  = !rx_sync_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign rx_byte    = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// Frame parser that streams a UART program image into instruction memory and holds the core.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned MAX_LEN      = 19,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_i,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic              busy
);

  localparam int unsigned TimeoutCycles = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TimerW = $clog2(TimeoutCycles + 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TimeoutCycles - 1);
  localparam logic [7:0] MaxLen = 8'(MAX_LEN);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx_i),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  loader_state_e     state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        chk_q, chk_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      addr_q  <= '0;
      chk_q   <= '0;
      timer_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      chk_q   <= chk_d;
      timer_q <= timer_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    chk_d   = chk_q;
    timer_d = (state_q == StIdle || byte_valid) ? '0 : timer_q + 1'b1;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (byte_valid && rx_byte == SyncByte) begin
          state_d = StLen;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end
      StLen: begin
        if (byte_valid) begin
          if (rx_byte != 8'd0 && rx_byte <= MaxLen) begin
            len_d   = rx_byte;
            addr_d  = '0;
            chk_d   = rx_byte;
            state_d = StData;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (byte_valid) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = rx_byte;
          addr_d  = addr_q + 1'b1;
          chk_d   = chk_q ^ rx_byte;
          if (8'(addr_q) + 8'd1 == len_q) state_d = StChk;
        end
      end
      StChk: begin
        if (byte_valid) begin
          if (rx_byte == chk_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Line errors and stalls abort any frame in progress; they are ignored while idle.
    if (state_q != StIdle && (frame_err || (!byte_valid && timer_q == TimerMax))) begin
      err_d   = 1'b1;
      state_d = StIdle;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = waddr_q;
  assign mem_data  = wdata_q;
  assign cpu_hold  = hold_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench: table of UART frames with a write scoreboard, plus corner-case sequences.
module tb_uart_program_loader;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;
  logic       busy;

  uart_program_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (5),
    .MAX_LEN     (19),
    .TIMEOUT_BITS(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_i     (rx),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .cpu_hold (cpu_hold),
    .load_done(load_done),
    .load_err (load_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct packed {
    logic [31:0][7:0] bytes;
    logic [7:0]       n;
    logic [19:0][7:0] wd;
    logic [7:0]       nw;
    logic             good;
  } vec_t;

  int  checks   = 0;
  int  failures = 0;
  int  n_writes = 0;
  int  n_done   = 0;
  int  n_rxb    = 0;
  wr_t exp_q[$];
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr=%0d data=%0h expected none", mem_addr,
                   mem_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", int'(mem_addr), int'(e.a));
          chk("wr_data", int'(mem_data), int'(e.d));
          chk("hold_during_write", int'(cpu_hold), 1);
        end
      end
      if (load_done) begin
        n_done++;
        chk("done_hold_low", int'(cpu_hold), 0);
        chk("done_we_exclusive", int'(mem_we), 0);
      end
      if (dut.u_rx.byte_valid) n_rxb++;
    end
  end

  task automatic idle_bits(input int nbits);
    rx = 1'b1;
    repeat (nbits * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [7:0] sh;
    sh = b;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = sh[0];
      sh = sh >> 1;
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic push_wr(input int a, input logic [7:0] d);
    wr_t e;
    e.a = 5'(a);
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic add_byte(inout vec_t v, input logic [7:0] b);
    v.bytes[v.n[4:0]] = b;
    v.n = v.n + 8'd1;
  endtask

  task automatic add_wr(inout vec_t v, input logic [7:0] d);
    v.wd[v.nw[4:0]] = d;
    v.nw = v.nw + 8'd1;
  endtask

  task automatic apply_vec(input int k);
    vec_t v;
    int   w0, d0;
    v  = vecs[k];
    w0 = n_writes;
    d0 = n_done;
    for (int i = 0; i < int'(v.nw); i++) push_wr(i, v.wd[i]);
    for (int i = 0; i < int'(v.n); i++) send_byte(v.bytes[i], 1'b1);
    idle_bits(3);
    chk($sformatf("v%0d_load_err", k), int'(load_err), int'(!v.good));
    chk($sformatf("v%0d_cpu_hold", k), int'(cpu_hold), int'(!v.good));
    chk($sformatf("v%0d_busy", k), int'(busy), 0);
    chk($sformatf("v%0d_done_count", k), n_done - d0, int'(v.good));
    chk($sformatf("v%0d_write_count", k), n_writes - w0, int'(v.nw));
    chk($sformatf("v%0d_pending", k), exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    logic [7:0] c, d;
    int         w0, r0;

    // v0 good, v1 bad checksum, v2/v3 bad length, v4 junk prefix,
    // v5 maximum length, v6 sync byte used as data.
    v = '0; add_byte(v, 8'hA5); add_byte(v, 8'h03); add_byte(v, 8'h01); add_byte(v, 8'h2A);
    add_byte(v, 8'h0A); add_byte(v, 8'h22);
    add_wr(v, 8'h01); add_wr(v, 8'h2A); add_wr(v, 8'h0A); v.good = 1'b1; vecs[0] = v;
    v.bytes[5] = 8'h21; v.good = 1'b0; vecs[1] = v;
    v = '0; add_byte(v, 8'hA5); add_byte(v, 8'h00); vecs[2] = v;
    v = '0; add_byte(v, 8'hA5); add_byte(v, 8'h14); vecs[3] = v;
    v = '0; add_byte(v, 8'h55); add_byte(v, 8'hFF); add_byte(v, 8'hA5); add_byte(v, 8'h02);
    add_byte(v, 8'h07); add_byte(v, 8'h0A); add_byte(v, 8'h0F);
    add_wr(v, 8'h07); add_wr(v, 8'h0A); v.good = 1'b1; vecs[4] = v;
    v = '0; add_byte(v, 8'hA5); add_byte(v, 8'h13); c = 8'h13;
    for (int i = 0; i < 19; i++) begin
      d = 8'(i * 13 + 5);
      add_byte(v, d); add_wr(v, d); c = c ^ d;
    end
    add_byte(v, c); v.good = 1'b1; vecs[5] = v;
    v = '0; add_byte(v, 8'hA5); add_byte(v, 8'h05);
    for (int i = 0; i < 5; i++) begin
      add_byte(v, 8'hA5); add_wr(v, 8'hA5);
    end
    add_byte(v, 8'hA0); v.good = 1'b1; vecs[6] = v;

    repeat (5) @(negedge clk);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_data", int'(mem_data), 0);
    chk("rst_cpu_hold", int'(cpu_hold), 1);
    chk("rst_load_done", int'(load_done), 0);
    chk("rst_load_err", int'(load_err), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    idle_bits(2);

    for (int k = 0; k < 7; k++) apply_vec(k);

    // Framing error on the second data byte: only the first byte is written.
    w0 = n_writes;
    push_wr(0, 8'h11);
    send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    idle_bits(3);
    chk("ferr_load_err", int'(load_err), 1);
    chk("ferr_busy", int'(busy), 0);
    chk("ferr_hold", int'(cpu_hold), 1);
    chk("ferr_writes", n_writes - w0, 1);
    chk("ferr_pending", exp_q.size(), 0);
    exp_q.delete();

    // Quarter-bit low glitch while idle must not produce a byte.
    r0 = n_rxb;
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    idle_bits(12);
    chk("glitch_bytes", n_rxb - r0, 0);
    chk("glitch_busy", int'(busy), 0);

    // Stall after LEN: still busy before the limit, error after it.
    send_byte(8'hA5, 1'b1); send_byte(8'h05, 1'b1);
    idle_bits(30);
    chk("stall_busy_before", int'(busy), 1);
    chk("stall_err_before", int'(load_err), 0);
    idle_bits(4);
    chk("stall_busy_after", int'(busy), 0);
    chk("stall_err_after", int'(load_err), 1);

    // Reset in the middle of the third data byte.
    w0 = n_writes;
    push_wr(0, 8'h11); push_wr(1, 8'h22);
    send_byte(8'hA5, 1'b1); send_byte(8'h04, 1'b1); send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rx = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mem_we", int'(mem_we), 0);
    chk("midrst_cpu_hold", int'(cpu_hold), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_load_err", int'(load_err), 0);
    chk("midrst_load_done", int'(load_done), 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_bits(2);
    chk("midrst_writes", n_writes - w0, 2);
    chk("midrst_pending", exp_q.size(), 0);
    exp_q.delete();
    apply_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
